// File: rtl/wb4_fifo_lib_pkg.sv
// Shared definitions for the WB4 FIFO library: bus-master state encoding and
// counter/pointer width helpers.
package wb4_fifo_lib_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDrain  = 2'd2
  } wb4_state_e;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/wb4_resp_buffer.sv
// Single-clock first-word-fall-through FIFO holding acked read data; the head
// word is kept in its own register so the output never depends on a memory read.
module wb4_resp_buffer
  import wb4_fifo_lib_pkg::*;
#(
  parameter int unsigned P_DATA_MSB = 7,
  parameter int unsigned P_DEPTH    = 4,
  localparam int unsigned LP_CW     = cnt_width(P_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_push,
  input  logic [P_DATA_MSB:0] i_data,
  input  logic                i_pop,
  output logic                o_valid,
  output logic [P_DATA_MSB:0] o_data,
  output logic [LP_CW-1:0]    o_count
);

  localparam int unsigned LP_PW = ptr_width(P_DEPTH);

  logic [P_DATA_MSB:0] r_mem [P_DEPTH];
  logic [LP_PW-1:0]    r_wr_ptr;
  logic [LP_PW-1:0]    r_rd_ptr;
  logic [LP_CW-1:0]    r_count;
  logic [P_DATA_MSB:0] r_head;
  logic [P_DATA_MSB:0] w_head_d;
  logic [LP_CW-1:0]    w_count_d;
  logic                w_push;
  logic                w_pop;
  logic [LP_PW-1:0]    w_rd_next;

  function automatic logic [LP_PW-1:0] ptr_inc(input logic [LP_PW-1:0] p);
    return (p == LP_PW'(P_DEPTH - 1)) ? '0 : p + LP_PW'(1);
  endfunction

  assign w_pop     = i_pop & (r_count != '0);
  assign w_push    = i_push & (r_count != LP_CW'(P_DEPTH));
  assign w_rd_next = ptr_inc(r_rd_ptr);

  always_comb begin
    w_head_d  = r_head;
    w_count_d = r_count;
    // The incoming word becomes the head only when it is the sole surviving entry.
    if (w_push && ((r_count == '0) || ((r_count == LP_CW'(1)) && w_pop))) begin
      w_head_d = i_data;
    end else if (w_pop && (r_count > LP_CW'(1))) begin
      w_head_d = r_mem[w_rd_next];
    end
    if (w_push && !w_pop) begin
      w_count_d = r_count + LP_CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - LP_CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      r_count <= w_count_d;
      r_head  <= w_head_d;
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_head;
  assign o_count = r_count;

endmodule

// File: rtl/wb4_fifo_drain_master.sv
// Wishbone B4 pipelined read master that drains a WB4 FIFO into a valid/ready
// stream, issuing strobes only while buffer space is guaranteed for every ack.
module wb4_fifo_drain_master
  import wb4_fifo_lib_pkg::*;
#(
  parameter int unsigned P_DATA_MSB        = 7,
  parameter int unsigned P_MAX_OUTSTANDING = 4,
  parameter int unsigned P_BURST_LEN       = 16,
  parameter int unsigned P_STALL_LIMIT     = 8
) (
  input  logic                i_wb4_mclk,
  input  logic                i_wb4_mrst,
  input  logic                i_enable,
  output logic                o_wb4_mcyc,
  output logic                o_wb4_mstb,
  input  logic                i_wb4_mstall,
  input  logic                i_wb4_mack,
  input  logic [P_DATA_MSB:0] i_wb4_mdata,
  output logic                o_stream_valid,
  input  logic                i_stream_ready,
  output logic [P_DATA_MSB:0] o_stream_data,
  output logic                o_busy
);

  localparam int unsigned LP_OW = cnt_width(P_MAX_OUTSTANDING);
  localparam int unsigned LP_UW = LP_OW + 1;
  localparam int unsigned LP_BW = cnt_width(P_BURST_LEN);
  localparam int unsigned LP_SW = cnt_width(P_STALL_LIMIT);

  wb4_state_e       r_state;
  wb4_state_e       w_state_d;
  logic [LP_OW-1:0] r_outstanding;
  logic [LP_OW-1:0] w_outstanding_d;
  logic [LP_BW-1:0] r_burst_cnt;
  logic [LP_BW-1:0] w_burst_cnt_d;
  logic [LP_SW-1:0] r_stall_cnt;
  logic [LP_SW-1:0] w_stall_cnt_d;
  logic [LP_OW-1:0] w_buf_count;
  logic [LP_UW-1:0] w_used;
  logic             w_credit_ok;
  logic             w_stb;
  logic             w_accept;
  logic             w_ack_ok;
  logic             w_pop;

  // Every in-flight strobe already owns a buffer slot, so an ack can never overflow.
  assign w_used      = LP_UW'(r_outstanding) + LP_UW'(w_buf_count);
  assign w_credit_ok = (w_used < LP_UW'(P_MAX_OUTSTANDING));
  assign w_stb       = (r_state == StActive) & w_credit_ok &
                       (r_burst_cnt != LP_BW'(P_BURST_LEN));
  assign w_accept    = w_stb & ~i_wb4_mstall;
  assign w_ack_ok    = i_wb4_mack & (r_outstanding != '0);
  assign w_pop       = o_stream_valid & i_stream_ready;

  always_comb begin
    w_state_d       = r_state;
    w_outstanding_d = r_outstanding;
    w_burst_cnt_d   = r_burst_cnt + LP_BW'(w_accept);
    w_stall_cnt_d   = (w_stb & i_wb4_mstall) ? r_stall_cnt + LP_SW'(1) : '0;

    unique case ({w_accept, w_ack_ok})
      2'b10:   w_outstanding_d = r_outstanding + LP_OW'(1);
      2'b01:   w_outstanding_d = r_outstanding - LP_OW'(1);
      default: w_outstanding_d = r_outstanding;
    endcase

    case (r_state)
      StIdle: begin
        if (i_enable && w_credit_ok) begin
          w_state_d     = StActive;
          w_burst_cnt_d = '0;
        end
      end
      StActive: begin
        if (!i_enable || (w_burst_cnt_d == LP_BW'(P_BURST_LEN)) ||
            (w_stall_cnt_d == LP_SW'(P_STALL_LIMIT))) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_outstanding_d == '0) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_wb4_mclk or posedge i_wb4_mrst) begin
    if (i_wb4_mrst) begin
      r_state       <= StIdle;
      r_outstanding <= '0;
      r_burst_cnt   <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_state       <= w_state_d;
      r_outstanding <= w_outstanding_d;
      r_burst_cnt   <= w_burst_cnt_d;
      r_stall_cnt   <= w_stall_cnt_d;
    end
  end

  wb4_resp_buffer #(
    .P_DATA_MSB (P_DATA_MSB),
    .P_DEPTH    (P_MAX_OUTSTANDING)
  ) u_resp_buffer (
    .i_clk   (i_wb4_mclk),
    .i_rst   (i_wb4_mrst),
    .i_push  (w_ack_ok),
    .i_data  (i_wb4_mdata),
    .i_pop   (w_pop),
    .o_valid (o_stream_valid),
    .o_data  (o_stream_data),
    .o_count (w_buf_count)
  );

  assign o_wb4_mcyc = (r_state != StIdle);
  assign o_wb4_mstb = w_stb;
  assign o_busy     = (r_state != StIdle);

endmodule

// File: doc/wb4_fifo_drain_master.md
# wb4_fifo_drain_master

Single-clock Wishbone B4 (pipelined) master that drains a WB4 FIFO read port (stall = empty, ack one cycle after accepted strobe) and re-presents the returned words as a valid/ready stream. Sits on the consumer side of the library's WB4 FIFOs, in the read-clock domain. It bounds outstanding requests with credits so acked data is never dropped, and it releases the bus on burst limit, idle stall or disable.

## Interface
- P_DATA_MSB, 7, data width-1
- P_MAX_OUTSTANDING, 4, max in-flight strobes; also response buffer depth (≥1)
- P_BURST_LEN, 16, max accepted strobes per cyc assertion (≥1)
- P_STALL_LIMIT, 8, consecutive stalled cycles in ACTIVE before releasing the bus (≥1)
- i_wb4_mclk  in  1  clock; one clock, all logic on rising edge
- i_wb4_mrst  in  1  reset, asynchronous, active-high
- i_enable  in  1  drain request
- o_wb4_mcyc  out  1  bus cycle
- o_wb4_mstb  out  1  read strobe
- i_wb4_mstall  in  1  slave stall (FIFO empty)
- i_wb4_mack  in  1  slave ack, qualifies i_wb4_mdata
- i_wb4_mdata  in  P_DATA_MSB+1  read data
- o_stream_valid  out  1  buffered word available
- i_stream_ready  in  1  downstream accept
- o_stream_data  out  P_DATA_MSB+1  head of response buffer
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE (cyc=0), ACTIVE (cyc=1, strobing), DRAIN (cyc=1, stb=0, collecting acks).
- outstanding: accepted strobes not yet acked; +1 on stb&~stall, -1 on ack with outstanding!=0, both at once = no change.
- credit = P_MAX_OUTSTANDING − buf_count − outstanding (never negative).
- o_wb4_mstb = (ACTIVE) & credit!=0 & burst_cnt!=P_BURST_LEN; combinational from registers only.
- burst_cnt: cleared entering ACTIVE, +1 per accepted strobe.
- stall_cnt: cleared on any cycle without stb&stall; +1 when stb&stall in ACTIVE.
- IDLE→ACTIVE: i_enable=1 and credit!=0.
- ACTIVE→DRAIN: i_enable=0, or burst_cnt reaches P_BURST_LEN (including the accepting cycle), or stall_cnt reaches P_STALL_LIMIT.
- DRAIN→IDLE: outstanding==0 after this cycle's update (last ack closes the cycle on that edge).
- IDLE lasts ≥1 cycle between cycles (cyc low at least one clock).
- Response buffer: push on ack with outstanding!=0; pop on valid&ready; simultaneous push/pop keeps count; overflow impossible by credit.
- Stray ack (outstanding==0): ignored, nothing pushed.

## Timing
- Reset (async assert): state IDLE, counters 0, buffer emptied; o_wb4_mcyc=0, o_wb4_mstb=0, o_stream_valid=0, o_stream_data=0, o_busy=0. In-flight data lost; release synchronous to clock.
- IDLE→first stb: i_enable sampled high at edge n → cyc and stb high in cycle n+1.
- Ack in cycle n → o_stream_valid/o_stream_data in cycle n+1; stream back-to-back at 1 word/clock.
- i_enable dropped in cycle n: a strobe in cycle n may still be accepted; stb low from n+1.
- Stb held (same request) while stall=1 unless credit/burst exhaustion gates it; no new state from a stalled strobe.
- Buffer full (buf_count=P_MAX_OUTSTANDING) → credit 0 → stb low; cyc stays high in ACTIVE.

## Structure
- Shared package wb4_fifo_lib_pkg: state encoding constants (IDLE/ACTIVE/DRAIN), counter-width helpers ($clog2(P_MAX_OUTSTANDING+1), $clog2(P_BURST_LEN+1)).
- One sub-module: wb4_resp_buffer (single-clock synchronous FIFO, depth P_MAX_OUTSTANDING, count output, registered data head, first-word fall-through).
- FSM, credit and counters live in the top.

## Test plan
- Reset mid-burst (2 outstanding, 3 buffered) → all outputs 0 in the asserting cycle, buffer empty after release.
- Slave holds 5 words, never stalls, ready=1, enable=1 → 5 accepted strobes, data 0x11..0x15 out in order, one word per clock, 1-cycle ack→valid latency.
- P_BURST_LEN=4, 10 words available → cyc high for exactly 4 accepted strobes plus drain, cyc low 1 cycle, new cycle starts; all 10 words delivered in order.
- ready=0, P_MAX_OUTSTANDING=4 → exactly 4 strobes accepted, stb stays low with cyc high; ready=1 one cycle → one new strobe.
- Slave empty (stall=1), P_STALL_LIMIT=8 → stb held 8 cycles, then DRAIN→IDLE, cyc low; o_busy follows.
- Stray ack while IDLE with data 0xAA → no push, o_stream_valid stays 0.
